pwm_duty_meter: RTL

//  Measures the period and high time of an external PWM waveform, such as the output of the breathing-LED generator.

---
 rtl/pwm_duty_meter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// pwm_duty_meter
//
// Measures the period and high time of an external PWM waveform. One
// measurement is published per input period. A line that shows no rising edge
// for TIMEOUT cycles is flagged as stuck, together with the level it is stuck at.
//
// Optional feature (define PWM_DUTY_PCT_EN): a sequential restoring divider
// turns each measurement into duty in whole percent (high*100/period,
// truncated). Without the macro, duty_pct and pct_valid are tied to 0.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst          in   asynchronous reset, active-high
//   pwm_in       in   asynchronous PWM input
//   meas_valid   out  one-cycle pulse: high_cnt/period_cnt updated
//   high_cnt     out  high cycles of the last complete period
//   period_cnt   out  total cycles of the last complete period
//   stuck        out  level: no rising edge for TIMEOUT cycles
//   stuck_level  out  synchronized pwm_in value when stuck was declared
//   duty_pct     out  0..100 duty in percent
//   pct_valid    out  one-cycle pulse: duty_pct updated
// -----------------------------------------------------------------------------
module pwm_duty_meter #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             stuck,
    output logic             stuck_level,
    output logic [6:0]       duty_pct,
    output logic             pct_valid
);

    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0] cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] period_sum;
    logic             timeout_hit;
    logic             restart, publish, to_low, inc_hi, inc_lo;
    logic             meas_valid_q, stuck_q, stuck_level_q;
    logic [CNT_W-1:0] high_cnt_q, period_cnt_q;

    // Two-flop synchronizer plus one flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;

    // A rise in the same cycle as the timeout wins, so stuck is never set then.
    assign timeout_hit = ~rise && (to_cnt_q == TO_LAST);
    assign period_sum  = cnt_hi_q + cnt_lo_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = HIGH;
            HIGH:    if (fall) state_d = LOW;
            LOW:     if (rise) state_d = HIGH;
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

    // FSM outputs
    always_comb begin
        restart = rise && (state_q != HIGH);
        publish = rise && (state_q == LOW);
        to_low  = fall && (state_q == HIGH);
        inc_hi  = sync2_q && (state_q == HIGH);
        inc_lo  = ~sync2_q && (state_q == LOW);
    end

    // Counter next state; cnt_hi/cnt_lo cannot wrap because the timeout fires first.
    always_comb begin
        cnt_hi_d = cnt_hi_q;
        cnt_lo_d = cnt_lo_q;
        if (restart) begin
            cnt_hi_d = CNT_W'(1);
            cnt_lo_d = '0;
        end else if (to_low) begin
            cnt_lo_d = CNT_W'(1);
        end else if (inc_hi) begin
            cnt_hi_d = cnt_hi_q + 1'b1;
        end else if (inc_lo) begin
            cnt_lo_d = cnt_lo_q + 1'b1;
        end

        if (rise)                   to_cnt_d = '0;
        else if (to_cnt_q == TO_MAX) to_cnt_d = to_cnt_q;
        else                        to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_hi_q <= '0;
            cnt_lo_q <= '0;
            to_cnt_q <= '0;
        end else begin
            cnt_hi_q <= cnt_hi_d;
            cnt_lo_q <= cnt_lo_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Published measurement and stuck status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_valid_q  <= 1'b0;
            high_cnt_q    <= '0;
            period_cnt_q  <= '0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            meas_valid_q <= publish;
            if (publish) begin
                high_cnt_q   <= cnt_hi_q;
                period_cnt_q <= period_sum;
            end
            if (rise) begin
                stuck_q <= 1'b0;
            end else if (timeout_hit) begin
                stuck_q       <= 1'b1;
                stuck_level_q <= sync2_q;
            end
        end
    end

    assign meas_valid  = meas_valid_q;
    assign high_cnt    = high_cnt_q;
    assign period_cnt  = period_cnt_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

`ifdef PWM_DUTY_PCT_EN
    // Restoring divider: quo_q starts holding the dividend (high*100) and
    // shifts quotient bits in from the bottom, one per cycle, QW cycles total.
    localparam int QW = CNT_W + 7;
    localparam int SW = $clog2(QW + 1);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic [CNT_W-1:0] dvs_q;
    logic [SW-1:0]    step_q;
    logic             busy_q;
    logic [6:0]       duty_q;
    logic             pct_valid_q;
    logic [CNT_W:0]   rem_sh;

    always_comb begin
        rem_sh = {rem_q, quo_q[QW-1]};
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d = CNT_W'(rem_sh - {1'b0, dvs_q});
            quo_d = {quo_q[QW-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[CNT_W-1:0];
            quo_d = {quo_q[QW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            step_q      <= '0;
            busy_q      <= 1'b0;
            duty_q      <= '0;
            pct_valid_q <= 1'b0;
        end else begin
            pct_valid_q <= 1'b0;
            if (timeout_hit) begin
                // A stuck line has a trivially known duty; abandon any division.
                busy_q      <= 1'b0;
                duty_q      <= sync2_q ? 7'd100 : 7'd0;
                pct_valid_q <= 1'b1;
            end else if (publish) begin
                // A new measurement restarts the divider, dropping any result in flight.
                busy_q <= 1'b1;
                rem_q  <= '0;
                quo_q  <= QW'(cnt_hi_q) * QW'(100);
                dvs_q  <= period_sum;
                step_q <= SW'(QW - 1);
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                if (step_q == '0) begin
                    busy_q      <= 1'b0;
                    duty_q      <= quo_d[6:0];
                    pct_valid_q <= 1'b1;
                end else begin
                    step_q <= step_q - 1'b1;
                end
            end
        end
    end

    assign duty_pct  = duty_q;
    assign pct_valid = pct_valid_q;
`else
    assign duty_pct  = 7'd0;
    assign pct_valid = 1'b0;
`endif

endmodule
